// File: rtl/uart_bus_ctrl.sv
// CPU-side register interface for the UART: mode/command programming, FIFO
// pop/push sequencing, sticky receive-error flags and the interrupt line.
module uart_bus_ctrl (
  input  logic       CLK50MHZ,
  input  logic       rst,
  input  logic       n_CS,
  input  logic       n_RD,
  input  logic       n_WR,
  input  logic       C_nD,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] rx_data,
  input  logic       Rx_RDY,
  input  logic       Tx_RDY,
  input  logic       PE_in,
  input  logic       FE_in,
  input  logic       OE_in,
  output logic       rx_rd,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       D_num,
  output logic       S_num,
  output logic [1:0] Par,
  output logic [1:0] baud_sel,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       Clr_EF,
  output logic       n_INT
);

  typedef enum logic {MODE_WAIT = 1'b0, CMD = 1'b1} state_t;

  state_t state;
  logic   wr_act, rd_act;
  logic   wr_act_p0, rd_act_p0;
  logic   wr_start, rd_start;
  logic   rx_ie;
  logic   pe_s, fe_s, oe_s;

  assign wr_act   = ~n_CS & ~n_WR;
  assign rd_act   = ~n_CS & ~n_RD;
  assign wr_start = wr_act & ~wr_act_p0;
  assign rd_start = rd_act & ~rd_act_p0;

  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      state     <= MODE_WAIT;
      wr_act_p0 <= 1'b0;
      rd_act_p0 <= 1'b0;
      dout      <= 8'h00;
      tx_data   <= 8'h00;
      rx_rd     <= 1'b0;
      tx_wr     <= 1'b0;
      Clr_EF    <= 1'b0;
      D_num     <= 1'b1;
      S_num     <= 1'b0;
      Par       <= 2'b00;
      baud_sel  <= 2'b00;
      rx_enable <= 1'b0;
      tx_enable <= 1'b0;
      rx_ie     <= 1'b0;
      pe_s      <= 1'b0;
      fe_s      <= 1'b0;
      oe_s      <= 1'b0;
      n_INT     <= 1'b1;
    end else begin
      // p0: strobe history for edge detection; pulses default low
      wr_act_p0 <= wr_act;
      rd_act_p0 <= rd_act;
      rx_rd     <= 1'b0;
      tx_wr     <= 1'b0;
      Clr_EF    <= 1'b0;
      n_INT     <= ~((rx_ie & Rx_RDY) | pe_s | fe_s | oe_s);

      if (state == CMD) begin
        if (PE_in) pe_s <= 1'b1;
        if (FE_in) fe_s <= 1'b1;
        if (OE_in) oe_s <= 1'b1;
      end

      // Clears below come after the sets so a clear wins in the same cycle
      if (wr_start) begin
        if (C_nD) begin
          if (state == MODE_WAIT) begin
            baud_sel <= din[1:0];
            D_num    <= din[2];
            S_num    <= din[3];
            Par      <= din[5:4];
            state    <= CMD;
          end else if (din[6]) begin
            tx_enable <= 1'b0;
            rx_enable <= 1'b0;
            rx_ie     <= 1'b0;
            pe_s      <= 1'b0;
            fe_s      <= 1'b0;
            oe_s      <= 1'b0;
            D_num     <= 1'b1;
            S_num     <= 1'b0;
            Par       <= 2'b00;
            baud_sel  <= 2'b00;
            state     <= MODE_WAIT;
          end else begin
            tx_enable <= din[0];
            rx_ie     <= din[1];
            rx_enable <= din[2];
            if (din[4]) begin
              Clr_EF <= 1'b1;
              pe_s   <= 1'b0;
              fe_s   <= 1'b0;
              oe_s   <= 1'b0;
            end
          end
        end else if (state == CMD && tx_enable && Tx_RDY) begin
          tx_data <= din;
          tx_wr   <= 1'b1;
        end
      end

      if (rd_start) begin
        if (C_nD) begin
          dout <= {2'b00, (state == MODE_WAIT), oe_s, fe_s, pe_s, Rx_RDY, Tx_RDY};
        end else if (Rx_RDY) begin
          dout  <= rx_data;
          rx_rd <= 1'b1;
        end else begin
          dout <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Scoreboard bench for uart_bus_ctrl: expected read data and transmit pushes
// are queued when the bus access is driven and retired when the DUT responds.
module tb_uart_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       n_CS, n_RD, n_WR, C_nD;
  logic [7:0] din, dout, rx_data, tx_data;
  logic       Rx_RDY, Tx_RDY, PE_in, FE_in, OE_in;
  logic       rx_rd, tx_wr, D_num, S_num, rx_enable, tx_enable, Clr_EF, n_INT;
  logic [1:0] Par, baud_sel;

  int n_vec = 0;
  int n_err = 0;
  int tx_cnt = 0;
  int rx_cnt = 0;
  int clr_cnt = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];

  // bench model of the state needed to predict transmit pushes
  logic m_cmd = 1'b0;
  logic m_tx_en = 1'b0;

  uart_bus_ctrl dut (
    .CLK50MHZ(clk), .rst(rst), .n_CS(n_CS), .n_RD(n_RD), .n_WR(n_WR),
    .C_nD(C_nD), .din(din), .dout(dout), .rx_data(rx_data), .Rx_RDY(Rx_RDY),
    .Tx_RDY(Tx_RDY), .PE_in(PE_in), .FE_in(FE_in), .OE_in(OE_in),
    .rx_rd(rx_rd), .tx_wr(tx_wr), .tx_data(tx_data), .D_num(D_num),
    .S_num(S_num), .Par(Par), .baud_sel(baud_sel), .rx_enable(rx_enable),
    .tx_enable(tx_enable), .Clr_EF(Clr_EF), .n_INT(n_INT)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] status(input logic mw, input logic oe,
                                        input logic fe, input logic pe);
    return {2'b00, mw, oe, fe, pe, Rx_RDY, Tx_RDY};
  endfunction

  // output side of the scoreboard: transmit pushes and pulse counters
  always @(negedge clk) begin
    if (tx_wr) begin
      tx_cnt++;
      if (exp_tx.size() == 0) check("tx_wr_unexpected", 1, 0);
      else check("tx_data", int'(tx_data), int'(exp_tx.pop_front()));
    end
    if (rx_rd) rx_cnt++;
    if (Clr_EF) clr_cnt++;
  end

  task automatic bus_wr(input logic cnd, input logic [7:0] d, input int hold);
    if (!cnd) begin
      if (m_cmd && m_tx_en && Tx_RDY) exp_tx.push_back(d);
    end else if (!m_cmd) begin
      m_cmd = 1'b1;
    end else if (d[6]) begin
      m_cmd = 1'b0;
      m_tx_en = 1'b0;
    end else begin
      m_tx_en = d[0];
    end
    @(negedge clk);
    n_CS = 1'b0; n_WR = 1'b0; C_nD = cnd; din = d;
    repeat (hold) @(negedge clk);
    n_CS = 1'b1; n_WR = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic cnd, input logic [7:0] exp, input int hold);
    @(negedge clk);
    n_CS = 1'b0; n_RD = 1'b0; C_nD = cnd;
    exp_rd.push_back(exp);
    @(negedge clk);
    check(cnd ? "status_rd" : "data_rd", int'(dout), int'(exp_rd.pop_front()));
    repeat (hold - 1) @(negedge clk);
    n_CS = 1'b1; n_RD = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; n_CS = 1'b1; n_RD = 1'b1; n_WR = 1'b1; C_nD = 1'b0;
    din = 8'h00; rx_data = 8'h00; Rx_RDY = 1'b0; Tx_RDY = 1'b0;
    PE_in = 1'b0; FE_in = 1'b0; OE_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_D_num", int'(D_num), 1);
    check("rst_S_num", int'(S_num), 0);
    check("rst_Par", int'(Par), 0);
    check("rst_baud", int'(baud_sel), 0);
    check("rst_en", int'({rx_enable, tx_enable}), 0);
    check("rst_n_INT", int'(n_INT), 1);
    check("rst_dout", int'(dout), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_pulses", int'({rx_rd, tx_wr, Clr_EF}), 0);
    bus_rd(1'b1, 8'h20, 1);

    // data write before the mode word must not push
    Tx_RDY = 1'b1;
    bus_wr(1'b0, 8'h99, 1);
    bus_rd(1'b1, status(1, 0, 0, 0), 1);

    bus_wr(1'b1, 8'h3D, 2);
    check("mode_baud", int'(baud_sel), 1);
    check("mode_D_num", int'(D_num), 1);
    check("mode_S_num", int'(S_num), 1);
    check("mode_Par", int'(Par), 3);
    bus_rd(1'b1, status(0, 0, 0, 0), 1);
    bus_wr(1'b1, 8'h07, 1);
    check("cmd_en", int'({rx_enable, tx_enable}), 3);

    bus_wr(1'b0, 8'hA5, 3);
    check("tx_cnt_a5", tx_cnt, 1);
    check("tx_data_a5", int'(tx_data), 'hA5);
    Tx_RDY = 1'b0;
    bus_wr(1'b0, 8'h3C, 2);
    check("tx_cnt_blocked", tx_cnt, 1);
    check("tx_data_held", int'(tx_data), 'hA5);
    Tx_RDY = 1'b1;

    Rx_RDY = 1'b1; rx_data = 8'h5A;
    @(negedge clk);
    check("n_INT_rxie", int'(n_INT), 0);
    bus_rd(1'b0, 8'h5A, 10);
    check("rx_cnt_one", rx_cnt, 1);
    check("dout_hold", int'(dout), 'h5A);
    Rx_RDY = 1'b0;
    repeat (2) @(negedge clk);
    check("n_INT_idle", int'(n_INT), 1);
    bus_rd(1'b0, 8'h00, 2);
    check("rx_cnt_empty", rx_cnt, 1);

    // framing error pulse: sticky until error reset
    FE_in = 1'b1;
    @(negedge clk);
    FE_in = 1'b0;
    @(negedge clk);
    check("n_INT_fe", int'(n_INT), 0);
    bus_rd(1'b1, status(0, 0, 1, 0), 1);
    bus_rd(1'b1, status(0, 0, 1, 0), 1);
    bus_wr(1'b1, 8'h17, 1);
    check("clr_ef_cnt", clr_cnt, 1);
    check("n_INT_cleared", int'(n_INT), 1);
    bus_rd(1'b1, status(0, 0, 0, 0), 1);

    // a held error input re-sets its flag after the clear
    FE_in = 1'b1;
    bus_wr(1'b1, 8'h17, 1);
    FE_in = 1'b0;
    check("clr_ef_cnt2", clr_cnt, 2);
    bus_rd(1'b1, status(0, 0, 1, 0), 1);
    bus_wr(1'b1, 8'h17, 1);

    PE_in = 1'b1; OE_in = 1'b1;
    @(negedge clk);
    PE_in = 1'b0; OE_in = 1'b0;
    bus_rd(1'b1, status(0, 1, 0, 1), 1);

    bus_wr(1'b1, 8'h40, 1);
    check("ireset_en", int'({rx_enable, tx_enable}), 0);
    check("ireset_D_num", int'(D_num), 1);
    check("ireset_S_num", int'(S_num), 0);
    check("ireset_Par", int'(Par), 0);
    check("ireset_baud", int'(baud_sel), 0);
    check("ireset_n_INT", int'(n_INT), 1);
    bus_rd(1'b1, status(1, 0, 0, 0), 1);

    // rst in the middle of a held control write
    bus_wr(1'b1, 8'h3D, 1);
    @(negedge clk);
    n_CS = 1'b0; n_WR = 1'b0; C_nD = 1'b1; din = 8'h2B;
    @(negedge clk);
    check("pre_rst_cmd", int'(tx_enable), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_tx_en", int'(tx_enable), 0);
    check("midrst_D_num", int'(D_num), 1);
    check("midrst_baud", int'(baud_sel), 0);
    check("midrst_tx_data", int'(tx_data), 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_n_INT", int'(n_INT), 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_CS = 1'b1; n_WR = 1'b1;
    @(negedge clk);
    m_cmd = 1'b1; m_tx_en = 1'b0;
    check("post_rst_baud", int'(baud_sel), 3);
    check("post_rst_D_num", int'(D_num), 0);
    check("post_rst_S_num", int'(S_num), 1);
    check("post_rst_Par", int'(Par), 2);
    check("post_rst_single", int'({rx_enable, tx_enable}), 0);
    bus_rd(1'b1, status(0, 0, 0, 0), 1);

    repeat (2) @(negedge clk);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("tx_cnt_final", tx_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_bus_ctrl.md
# uart_bus_ctrl

CPU-side bus controller for the UART. It decodes CPU read/write strobes into register accesses and holds the line configuration (data bits, stop bits, parity, baud select) and the enables that drive the receiver and transmitter. It also sequences the receive-FIFO pops and transmit-FIFO pushes, latches sticky error flags, and generates the interrupt. Like an 8251, it uses a mode-then-command programming sequence: after reset, the first control write is the mode word and every later control write is a command word.

## Interface
Parameters: none.

Ports:
- CLK50MHZ  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- n_CS  in  1  chip select, active low
- n_RD  in  1  CPU read strobe, active low
- n_WR  in  1  CPU write strobe, active low
- C_nD  in  1  1 = control/status access, 0 = data access
- din  in  8  CPU write data
- dout  out  8  CPU read data (registered)
- rx_data  in  8  head of the receive FIFO
- Rx_RDY  in  1  receive FIFO holds at least one character
- Tx_RDY  in  1  transmit FIFO can accept a character
- PE_in, FE_in, OE_in  in  1 each  parity, framing and overrun error levels from the receiver
- rx_rd  out  1  one-cycle pop of the receive FIFO
- tx_wr  out  1  one-cycle push to the transmit FIFO
- tx_data  out  8  data for tx_wr
- D_num  out  1  1 = 8 data bits, 0 = 7
- S_num  out  1  1 = 2 stop bits, 0 = 1
- Par  out  2  00 none, 01 odd, 10 even, 11 invalid
- baud_sel  out  2  baud generator rate select
- rx_enable, tx_enable  out  1 each  receiver and transmitter enables
- Clr_EF  out  1  one-cycle error-flag clear to the receiver
- n_INT  out  1  interrupt, active low (registered)

## Operation
- Access events:
  - wr_act = ~n_CS & ~n_WR; rd_act = ~n_CS & ~n_RD.
  - Each is registered every cycle.
  - wr_start = wr_act & ~wr_act_q, and rd_start is formed the same way.
  - Exactly one action is taken per strobe, regardless of how long the strobe is held.
  - Read and write starts in the same cycle are both processed.
- State MODE_WAIT (entered on reset):
  - A control write (C_nD=1) loads the mode fields: baud_sel=din[1:0], D_num=din[2], S_num=din[3], Par=din[5:4]. The state then moves to CMD.
  - A data write in this state is ignored.
- State CMD:
  - A control write is a command word: tx_enable=din[0], rx_ie=din[1], rx_enable=din[2].
  - din[4] (error reset) pulses Clr_EF and clears all sticky flags.
  - din[6] (internal reset) clears tx_enable, rx_enable, rx_ie and the sticky flags, restores the mode defaults, and returns to MODE_WAIT. When din[6] is set, the other command bits are ignored.
- Data write in CMD:
  - If tx_enable=1 and Tx_RDY=1, tx_data is set to din and tx_wr pulses.
  - Otherwise the write is dropped and no pulse is issued.
- Status read (C_nD=1):
  - dout = {2'b00, mode_wait, OE_s, FE_s, PE_s, Rx_RDY, Tx_RDY}.
  - mode_wait is 1 in MODE_WAIT.
- Data read (C_nD=0):
  - If Rx_RDY=1, dout = rx_data and rx_rd pulses.
  - If Rx_RDY=0, dout = 8'h00 and there is no pop.
  - dout holds its value until the next read start.
- Sticky flags PE_s, FE_s and OE_s:
  - Each is set in CMD whenever its *_in is high.
  - Each holds until an error reset, an internal reset or rst.
  - When a clear and a set occur in the same cycle, the clear wins. An input that stays high sets its flag again on the next cycle.
- Interrupt: n_INT is registered as ~((rx_ie & Rx_RDY) | PE_s | FE_s | OE_s).

## Timing
- Reset values, after a rst edge:
  - state MODE_WAIT; dout 8'h00; tx_data 8'h00
  - rx_rd, tx_wr, Clr_EF = 0
  - D_num 1, S_num 0, Par 00, baud_sel 00
  - rx_enable, tx_enable, rx_ie = 0
  - sticky flags 0; n_INT 1
- rst mid-access: the strobe history is cleared. A strobe still held low after reset therefore creates a new start on the first cycle after reset.
- Write latency: at the edge where wr_start=1, the configuration, tx_data and state update. tx_wr and Clr_EF are high for exactly the cycle following that edge.
- Read latency: dout is valid one cycle after the rd_start edge. rx_rd is high for exactly that one cycle. The FIFO head advances after it.
- Sticky flags: a sticky flag is visible one cycle after its *_in rises. n_INT follows one cycle later.
- Minimum strobe: strobes must be high for at least 1 cycle between accesses. Back-to-back starts are 2 cycles apart.

## Test plan
- Reset, then status read -> dout=8'h20 (mode_wait=1, Rx_RDY=0, Tx_RDY=0 driven 0); D_num=1, S_num=0, Par=00, n_INT=1.
- Control write 8'h3D, then control write 8'h07 -> baud_sel=01, D_num=1, S_num=1, Par=11; tx_enable=1, rx_ie=1, rx_enable=1; status bit5=0.
- In CMD with tx_enable=1: data write 8'hA5 with Tx_RDY=1 -> one tx_wr pulse, tx_data=8'hA5. Repeat with Tx_RDY=0 -> no tx_wr.
- Rx_RDY=1, rx_data=8'h5A, n_RD held low for 10 cycles -> dout=8'h5A, a single rx_rd pulse, n_INT low while rx_ie=1. Read with Rx_RDY=0 -> dout=8'h00, no pulse.
- FE_in pulsed for 1 cycle -> status bit3=1 until command 8'h17; that command gives one Clr_EF pulse, status bit3=0, and n_INT=1 once Rx_RDY=0.
- Command 8'h40 -> MODE_WAIT, all enables 0, mode defaults restored. rst asserted during a held n_WR -> reset values, then exactly one write processed.
